hazard_fwd_ctrl: RTL

//  Pipeline hazard controller for the 5-stage MIPS core: generates the select inputs that drive the
//  32-bit 2:1/3:1 operand-forwarding muxes in front of the ALU, plus stall/flush controls.

---
 rtl/hazard_pkg.sv | 28 ++
 rtl/dst_track_pipe.sv | 41 ++++
 rtl/hazard_fwd_ctrl.sv | 112 +++++++++++
 3 files changed

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard / forwarding controller.
// Holds the forward-select encoding, register index width, the destination
// scoreboard entry layout, the control FSM state type and a small hit helper.
package hazard_pkg;

  localparam int unsigned REG_ADDR_W = 5;
  localparam int unsigned SEL_W      = 2;

  // ALU operand mux select; 2'b11 is unused and never driven
  localparam logic [SEL_W-1:0] FWD_NONE  = 2'b00;
  localparam logic [SEL_W-1:0] FWD_EXMEM = 2'b01;
  localparam logic [SEL_W-1:0] FWD_MEMWB = 2'b10;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] dst;
    logic                  reg_write;
    logic                  mem_read;
  } sb_entry_t;

  typedef enum logic {StRun, StBubble} ctrl_state_e;

  // True when the entry will write register r; $0 never counts as a write
  function automatic logic entry_writes(input sb_entry_t e, input logic [REG_ADDR_W-1:0] r);
    return e.valid & e.reg_write & (e.dst == r) & (r != '0);
  endfunction

endpackage

// File: rtl/dst_track_pipe.sv
// Destination-register scoreboard: three-deep EX/MEM/WB shift pipe.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   id_entry_i   entry describing the instruction leaving ID
//   bubble_i     load an invalid (all-zero) entry into EX instead of id_entry_i
//   ex_o, mem_o  current EX and MEM stage entries
// The WB entry is kept only for debug/assertions: the register file writes in
// the first half-cycle, so nothing forwards from it.
module dst_track_pipe
  import hazard_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  sb_entry_t id_entry_i,
  input  logic      bubble_i,
  output sb_entry_t ex_o,
  output sb_entry_t mem_o
);

  sb_entry_t ex_q, mem_q, wb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
    end else begin
      wb_q  <= mem_q;
      mem_q <= ex_q;
      ex_q  <= bubble_i ? '0 : id_entry_i;
    end
  end

  assign ex_o  = ex_q;
  assign mem_o = mem_q;

  // Bubbles are stored as all-zero entries, so an invalid entry carries no stale fields
  a_wb_bubble_clean: assert property (@(posedge clk) disable iff (!rst_n)
    !wb_q.valid |-> (wb_q == '0));

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard controller for the 5-stage MIPS core.
// Produces registered ALU operand forward selects, combinational stall/flush
// controls and a registered EX-bubble flag, from its own destination scoreboard.
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   id_*                instruction currently in ID (sources, uses, destination, kind)
//   ex_branch_taken     branch/jump resolved taken in EX
//   fwd_a_sel/fwd_b_sel operand mux selects, stable for the whole EX cycle
//   stall_if/stall_id   hold PC and IF/ID on a load-use hazard
//   flush_id            clear IF/ID on a taken branch
//   ex_bubble           EX holds an inserted bubble
module hazard_fwd_ctrl #(
  parameter int unsigned REG_ADDR_W = hazard_pkg::REG_ADDR_W,
  parameter int unsigned SEL_W      = hazard_pkg::SEL_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rs,
  input  logic                  id_uses_rt,
  input  logic [REG_ADDR_W-1:0] id_dst,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  input  logic                  ex_branch_taken,
  output logic [SEL_W-1:0]      fwd_a_sel,
  output logic [SEL_W-1:0]      fwd_b_sel,
  output logic                  stall_if,
  output logic                  stall_id,
  output logic                  flush_id,
  output logic                  ex_bubble
);

  import hazard_pkg::*;

  sb_entry_t   id_entry, ex_e, mem_e;
  logic        ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt;
  logic        load_use, insert_bubble, id_advance;
  logic [SEL_W-1:0] fwd_a_d, fwd_a_q, fwd_b_d, fwd_b_q;
  ctrl_state_e state_d, state_q;

  assign id_entry = '{valid: id_valid, dst: id_dst, reg_write: id_reg_write,
                      mem_read: id_mem_read};

  dst_track_pipe u_dst_track_pipe (
    .clk        (clk),
    .rst_n      (rst_n),
    .id_entry_i (id_entry),
    .bubble_i   (insert_bubble),
    .ex_o       (ex_e),
    .mem_o      (mem_e)
  );

  assign ex_hit_rs  = id_uses_rs & entry_writes(ex_e, id_rs);
  assign ex_hit_rt  = id_uses_rt & entry_writes(ex_e, id_rt);
  assign mem_hit_rs = id_uses_rs & entry_writes(mem_e, id_rs);
  assign mem_hit_rt = id_uses_rt & entry_writes(mem_e, id_rt);

  assign load_use = id_valid & ex_e.mem_read & (ex_hit_rs | ex_hit_rt);

  // Flush wins over stall: a taken branch discards the stalled consumer anyway
  assign stall_if = load_use & ~ex_branch_taken;
  assign stall_id = load_use & ~ex_branch_taken;
  assign flush_id = ex_branch_taken;

  assign insert_bubble = load_use | ex_branch_taken | ~id_valid;
  assign id_advance    = id_valid & ~load_use & ~ex_branch_taken;

  always_comb begin
    fwd_a_d = FWD_NONE;
    fwd_b_d = FWD_NONE;
    state_d = state_q;

    // Selects are captured as the consumer moves into EX: a producer now in EX
    // will be in EX/MEM then, one now in MEM will be in MEM/WB. Newer wins.
    if (id_advance) begin
      if (ex_hit_rs)       fwd_a_d = FWD_EXMEM;
      else if (mem_hit_rs) fwd_a_d = FWD_MEMWB;
      if (ex_hit_rt)       fwd_b_d = FWD_EXMEM;
      else if (mem_hit_rt) fwd_b_d = FWD_MEMWB;
    end

    unique case (state_q)
      StRun:    if (load_use | ex_branch_taken) state_d = StBubble;
      StBubble: state_d = (load_use | ex_branch_taken) ? StBubble : StRun;
      default:  state_d = StRun;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwd_a_q <= FWD_NONE;
      fwd_b_q <= FWD_NONE;
      state_q <= StRun;
    end else begin
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      state_q <= state_d;
    end
  end

  assign fwd_a_sel = fwd_a_q;
  assign fwd_b_sel = fwd_b_q;
  assign ex_bubble = (state_q == StBubble);

  a_fwd_a_legal: assert property (@(posedge clk) disable iff (!rst_n) fwd_a_q != 2'b11);
  a_fwd_b_legal: assert property (@(posedge clk) disable iff (!rst_n) fwd_b_q != 2'b11);
  a_mem_bubble_clean: assert property (@(posedge clk) disable iff (!rst_n)
    !mem_e.valid |-> (mem_e == '0));

endmodule
